// File: rtl/delay_unit_timer_pkg.sv
// Shared definitions for the delay unit timer: FSM state type, default
// parameter values and the unit-counter width helper.
package delay_unit_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_DELAY_W         = 4;
    localparam int unsigned DEFAULT_CYCLES_PER_UNIT = 1000;

    // Width of a counter that holds 0 .. n-1 (never narrower than one bit).
    function automatic int unsigned unit_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/unit_down_counter.sv
// Mod-N down counter: load sets it to N-1, enable counts down and wraps
// from 0 back to N-1; zero flags the terminal value.
module unit_down_counter
    import delay_unit_timer_pkg::*;
#(
    parameter int unsigned N = DEFAULT_CYCLES_PER_UNIT,
    parameter int unsigned W = unit_width(N)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic ena,
    output logic zero
);

    localparam logic [W-1:0] TOP = W'(N - 1);

    logic [W-1:0] unit_q;

    // Unit register: load has priority over the enabled down-count.
    always_ff @(posedge clk) begin
        if (reset) begin
            unit_q <= '0;
        end else if (load) begin
            unit_q <= TOP;
        end else if (ena) begin
            unit_q <= (unit_q == '0) ? TOP : unit_q - W'(1);
        end
    end

    // Terminal flag decoded from the register.
    always_comb begin
        zero = (unit_q == '0);
    end

endmodule

// File: rtl/delay_unit_timer.sv
// Captures a serial delay value while shift_ena is high, then counts
// (delay+1) units of CYCLES_PER_UNIT clocks and holds done until ack.
module delay_unit_timer
    import delay_unit_timer_pkg::*;
#(
    parameter int unsigned DELAY_W         = DEFAULT_DELAY_W,
    parameter int unsigned CYCLES_PER_UNIT = DEFAULT_CYCLES_PER_UNIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data,
    input  logic               shift_ena,
    input  logic               ack,
    output logic               counting,
    output logic [DELAY_W-1:0] count,
    output logic               done
);

    state_t             state;
    state_t             state_nx;
    logic [DELAY_W-1:0] delay_q;
    logic [DELAY_W-1:0] delay_nx;
    logic [DELAY_W-1:0] shifted;
    logic               unit_zero;
    logic               unit_load;
    logic               unit_ena;

    // Delay register shifted left by one with data entering at the LSB.
    generate
        if (DELAY_W == 1) begin : g_shift_one
            always_comb begin
                shifted = data;
            end
        end else begin : g_shift_many
            always_comb begin
                shifted = {delay_q[DELAY_W-2:0], data};
            end
        end
    endgenerate

    unit_down_counter #(
        .N (CYCLES_PER_UNIT)
    ) u_unit (
        .clk   (clk),
        .reset (reset),
        .load  (unit_load),
        .ena   (unit_ena),
        .zero  (unit_zero)
    );

    // State and delay registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            delay_q <= '0;
        end else begin
            state   <= state_nx;
            delay_q <= delay_nx;
        end
    end

    // Next-state, delay update and unit counter control.
    // The unit counter wraps to N-1 on its own, so a unit boundary with
    // delay left only needs the enable plus a delay decrement here.
    always_comb begin
        state_nx  = state;
        delay_nx  = delay_q;
        unit_load = 1'b0;
        unit_ena  = 1'b0;
        case (state)
            IDLE: begin
                if (shift_ena) begin
                    delay_nx = shifted;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (shift_ena) begin
                    delay_nx = shifted;
                end else begin
                    state_nx  = COUNT;
                    unit_load = 1'b1;
                end
            end
            COUNT: begin
                if (!unit_zero) begin
                    unit_ena = 1'b1;
                end else if (delay_q != '0) begin
                    unit_ena = 1'b1;
                    delay_nx = delay_q - DELAY_W'(1);
                end else begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from registers only.
    always_comb begin
        counting = (state == COUNT);
        done     = (state == DONE);
        count    = delay_q;
    end

endmodule

// File: tb/tb_delay_unit_timer.sv
// Scoreboard bench for delay_unit_timer: a cycle model pushes expected
// outputs each posedge, a monitor pops and compares each negedge, and the
// directed sequence checks hand-computed lengths and count values.
module tb_delay_unit_timer;

    localparam int CPU_A = 4;
    localparam int CPU_B = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sh_a = 1'b0, d_a = 1'b0, ack_a = 1'b0;
    logic       sh_b = 1'b0, d_b = 1'b0, ack_b = 1'b0;
    logic       cnt_a, done_a, cnt_b, done_b;
    logic [3:0] count_a, count_b;

    always #5 clk = ~clk;

    delay_unit_timer #(.DELAY_W(4), .CYCLES_PER_UNIT(CPU_A)) dut_a (
        .clk(clk), .reset(reset), .data(d_a), .shift_ena(sh_a), .ack(ack_a),
        .counting(cnt_a), .count(count_a), .done(done_a)
    );

    delay_unit_timer #(.DELAY_W(4), .CYCLES_PER_UNIT(CPU_B)) dut_b (
        .clk(clk), .reset(reset), .data(d_b), .shift_ena(sh_b), .ack(ack_b),
        .counting(cnt_b), .count(count_b), .done(done_b)
    );

    typedef struct {
        int st;
        int dly;
        int unit;
    } mdl_t;

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
    } exp_t;

    mdl_t ma = '{0, 0, 0};
    mdl_t mb = '{0, 0, 0};
    exp_t sbq[$];
    int   seen[$];
    int   checks = 0;
    int   failures = 0;

    function automatic mdl_t step(mdl_t m, bit rst, bit sh, bit d, bit ak, int cpu);
        mdl_t n = m;
        if (rst) begin
            n.st = 0; n.dly = 0; n.unit = 0;
            return n;
        end
        case (m.st)
            0: if (sh) begin n.dly = ((m.dly << 1) | int'(d)) & 15; n.st = 1; end
            1: if (sh) n.dly = ((m.dly << 1) | int'(d)) & 15;
               else begin n.st = 2; n.unit = cpu - 1; end
            2: if (m.unit != 0) n.unit = m.unit - 1;
               else if (m.dly != 0) begin n.dly = m.dly - 1; n.unit = cpu - 1; end
               else n.st = 3;
            default: if (ak) n.st = 0;
        endcase
        return n;
    endfunction

    function automatic logic [5:0] outs(mdl_t m);
        return {m.st == 2, m.st == 3, 4'(m.dly)};
    endfunction

    function void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model advances on the same edge as the DUTs and queues expectations.
    always @(posedge clk) begin
        exp_t e;
        ma = step(ma, reset, sh_a, d_a, ack_a, CPU_A);
        mb = step(mb, reset, sh_b, d_b, ack_b, CPU_B);
        e.a = outs(ma);
        e.b = outs(mb);
        sbq.push_back(e);
    end

    // Monitor compares every cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=0 required=1 at %0t", $time);
        end else begin
            e = sbq.pop_front();
            check("model_a", {26'd0, cnt_a, done_a, count_a}, {26'd0, e.a});
            check("model_b", {26'd0, cnt_b, done_b, count_b}, {26'd0, e.b});
        end
    end

    task automatic shift(input bit sel, input int n, input logic [15:0] bits);
        for (int i = n - 1; i >= 0; i--) begin
            if (sel) begin sh_b = 1'b1; d_b = bits[i]; end
            else     begin sh_a = 1'b1; d_a = bits[i]; end
            @(negedge clk);
        end
        sh_a = 1'b0; d_a = 1'b0;
        sh_b = 1'b0; d_b = 1'b0;
    endtask

    // Records count on every counting cycle until done; bounded by budget.
    task automatic measure(input bit sel, input int budget);
        seen.delete();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sel ? done_b : done_a) begin
                ack_a = 1'b0;
                ack_b = 1'b0;
                return;
            end
            if (sel ? cnt_b : cnt_a) seen.push_back(int'(sel ? count_b : count_a));
        end
        checks++;
        failures++;
        $display("FAIL measure_timeout actual=%0d required_done_within=%0d", seen.size(), budget);
    endtask

    task automatic ack_pulse(input bit sel);
        if (sel) ack_b = 1'b1; else ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        ack_b = 1'b0;
        if (sel) check("ack_idle_b", {29'd0, cnt_b, done_b, |count_b}, 32'd0);
        else     check("ack_idle_a", {29'd0, cnt_a, done_a, |count_a}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_a", {26'd0, cnt_a, done_a, count_a}, 32'd0);
        check("reset_b", {26'd0, cnt_b, done_b, count_b}, 32'd0);
        reset = 1'b0;

        // delay=2: 12 counting cycles, count 2,2,2,2,1,...,0
        shift(0, 4, 16'b0010);
        measure(0, 100);
        check("t1_len", seen.size(), 12);
        check("t1_c0", seen[0], 2);
        check("t1_c3", seen[3], 2);
        check("t1_c4", seen[4], 1);
        check("t1_c7", seen[7], 1);
        check("t1_c8", seen[8], 0);
        check("t1_c11", seen[11], 0);
        check("t1_done", {27'd0, done_a, count_a}, 32'h10);

        // done held without ack; ack with simultaneous shift goes to IDLE only
        repeat (10) begin
            @(negedge clk);
            check("t5_hold", {31'd0, done_a}, 32'd1);
        end
        ack_a = 1'b1; sh_a = 1'b1; d_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0; sh_a = 1'b0; d_a = 1'b0;
        check("t5_ack", {26'd0, cnt_a, done_a, count_a}, 32'd0);
        @(negedge clk);
        check("t5_idle", {26'd0, cnt_a, done_a, count_a}, 32'd0);

        // delay=0: exactly one unit
        shift(0, 4, 16'b0000);
        measure(0, 100);
        check("t2_len", seen.size(), 4);
        check("t2_done", {27'd0, done_a, count_a}, 32'h10);
        ack_pulse(0);

        // six bits keep the last four (14); ack held through COUNT is ignored
        shift(0, 6, 16'b101110);
        ack_a = 1'b1;
        measure(0, 200);
        check("t3_len", seen.size(), 60);
        check("t3_c0", seen[0], 14);
        check("t3_c59", seen[59], 0);
        @(negedge clk);
        check("t3_done_hold", {31'd0, done_a}, 32'd1);
        ack_pulse(0);

        // three bits zero-filled: 0101 = 5
        shift(0, 3, 16'b101);
        measure(0, 100);
        check("t3b_len", seen.size(), 24);
        check("t3b_c0", seen[0], 5);
        ack_pulse(0);

        // reset mid-COUNT
        shift(0, 4, 16'b1001);
        repeat (10) @(negedge clk);
        check("t4_mid", {27'd0, cnt_a, count_a}, 32'h17);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_reset", {26'd0, cnt_a, done_a, count_a}, 32'd0);
        shift(0, 4, 16'b0011);
        measure(0, 100);
        check("t4_len", seen.size(), 16);
        check("t4_c0", seen[0], 3);
        ack_pulse(0);

        // long unit: delay=15, 1000 cycles per unit
        shift(1, 4, 16'b1111);
        measure(1, 17000);
        check("t6_len", seen.size(), 16000);
        check("t6_c0", seen[0], 15);
        check("t6_c15999", seen[15999], 0);
        check("t6_done", {27'd0, done_b, count_b}, 32'h10);
        ack_pulse(1);

        repeat (3) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
